// File: rtl/txn_arbiter.sv
// rtl/txn_arbiter.sv - round-robin transaction arbiter with bounded grant locking
// One bubble cycle per new grant; a locked grantee keeps the path for at most MAX_LOCK beats.
module txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [GW-1:0] grant_nx;
  logic [GW-1:0] last_grant, last_nx;
  logic [7:0]    lock_cnt, lock_nx;

  logic          found;
  logic [GW-1:0] sel;
  logic          g_valid;
  logic          g_lock;
  logic          beat;
  logic          lock_hit;

  // Round-robin search starting just after the previous grantee.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  assign g_valid  = req_valid[grant_id];
  assign g_lock   = req_lock[grant_id];
  assign out_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign lock_hit = (lock_cnt >= 8'(MAX_LOCK - 1));

  always_comb begin
    state_nx  = state;
    grant_nx  = grant_id;
    last_nx   = last_grant;
    lock_nx   = lock_cnt;
    out_valid = 1'b0;
    req_ready = '0;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        lock_nx = '0;
        if (found) begin
          grant_nx = sel;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        out_valid           = g_valid;
        req_ready[grant_id] = out_ready;
        beat                = g_valid && out_ready;
        if (beat) begin
          if (!g_lock || lock_hit) begin
            state_nx = IDLE;
            last_nx  = grant_id;
            lock_nx  = '0;
          end else begin
            lock_nx = lock_cnt + 8'd1;
          end
        end else if (!g_valid && !g_lock) begin
          state_nx = IDLE;
          lock_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        lock_nx  = '0;
      end
    endcase
    // Reset suppresses handshakes immediately so a mid-beat reset transfers nothing.
    if (rst) begin
      out_valid = 1'b0;
      req_ready = '0;
    end
  end

  assign busy = (state == ACTIVE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      lock_cnt   <= '0;
    end else begin
      state      <= state_nx;
      grant_id   <= grant_nx;
      last_grant <= last_nx;
      lock_cnt   <= lock_nx;
    end
  end

endmodule
